// File: rtl/sna_response_receiver_pkg.sv
// Shared sizes, FSM encoding and AXI response codes for the SNA response receiver.
package sna_response_receiver_pkg;
   localparam int unsigned FifoDepth = 4;
   localparam int unsigned AddrWidth = 4;
   localparam int unsigned DataWidth = 32;
   localparam int unsigned NumVc     = 8;
   localparam int unsigned VcWidth   = $clog2(NumVc);

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StAlloc = 2'd1,
      StSend  = 2'd2
   } state_e;

   localparam logic [1:0] RespOkay   = 2'b00;
   localparam logic [1:0] RespSlverr = 2'b10;
endpackage

// File: rtl/sna_tag_fifo.sv
// Small tag FIFO; a push into a full FIFO is accepted only when a pop frees a slot that cycle.
module sna_tag_fifo #(
   parameter int unsigned Width = 4,
   parameter int unsigned Depth = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [Width-1:0] push_data,
   input  logic             pop,
   output logic [Width-1:0] head,
   output logic             full,
   output logic             empty,
   output logic             drop
);
   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = $clog2(Depth + 1);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  rd_ptr_q, wr_ptr_q;
   logic [CntW-1:0]  count_q;
   logic             do_push, do_pop;

   assign full    = (count_q == CntW'(Depth));
   assign empty   = (count_q == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign drop    = push && !do_push;
   assign head    = mem_q[rd_ptr_q];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_pop) begin
            rd_ptr_q <= (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
         end
         if (do_push) begin
            wr_ptr_q <= (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
         end
         if (do_push && !do_pop) begin
            count_q <= count_q + 1'b1;
         end else if (do_pop && !do_push) begin
            count_q <= count_q - 1'b1;
         end
      end
   end

   // Storage needs no reset; validity is tracked by count_q.
   always_ff @(posedge clock) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end
endmodule

// File: rtl/sna_response_receiver.sv
// Turns AXI4-Lite R/B responses into single NoC flits routed back to the tagged requester.
module sna_response_receiver
   import sna_response_receiver_pkg::*;
(
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 rd_tag_push,
   input  logic                 wr_tag_push,
   input  logic [AddrWidth-1:0] tag_pov_addr,
   input  logic [DataWidth-1:0] rdata,
   input  logic [1:0]           rresp,
   input  logic                 rvalid,
   output logic                 rready,
   input  logic [1:0]           bresp,
   input  logic                 bvalid,
   output logic                 bready,
   input  logic [NumVc-1:0]     is_on_off,
   input  logic [NumVc-1:0]     is_allocatable,
   output logic [DataWidth-1:0] out_data,
   output logic [1:0]           out_resp,
   output logic                 out_is_read,
   output logic [AddrWidth-1:0] out_dest,
   output logic [VcWidth-1:0]   out_vc,
   output logic                 out_valid,
   output logic                 tag_overflow
);
   state_e               state_q, state_d;
   logic                 prefer_b_q;
   logic [AddrWidth-1:0] rd_head, wr_head;
   logic                 rd_full, wr_full, rd_empty, wr_empty, rd_drop, wr_drop;
   logic                 r_elig, b_elig, grant_r, grant_b;
   logic                 vc_found;
   logic [VcWidth-1:0]   vc_sel;

   sna_tag_fifo #(.Width(AddrWidth), .Depth(FifoDepth)) u_rd_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (rd_tag_push),
      .push_data (tag_pov_addr),
      .pop       (rready),
      .head      (rd_head),
      .full      (rd_full),
      .empty     (rd_empty),
      .drop      (rd_drop)
   );

   sna_tag_fifo #(.Width(AddrWidth), .Depth(FifoDepth)) u_wr_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (wr_tag_push),
      .push_data (tag_pov_addr),
      .pop       (bready),
      .head      (wr_head),
      .full      (wr_full),
      .empty     (wr_empty),
      .drop      (wr_drop)
   );

   assign r_elig    = rvalid && !rd_empty;
   assign b_elig    = bvalid && !wr_empty;
   assign grant_r   = r_elig && (!b_elig || !prefer_b_q);
   assign grant_b   = b_elig && !grant_r;
   assign out_valid = (state_q == StSend);

   // Descending scan so the lowest usable VC wins.
   always_comb begin
      vc_found = 1'b0;
      vc_sel   = '0;
      for (int i = int'(NumVc) - 1; i >= 0; i--) begin
         if (is_allocatable[i] && is_on_off[i]) begin
            vc_found = 1'b1;
            vc_sel   = VcWidth'(i);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      rready  = 1'b0;
      bready  = 1'b0;
      unique case (state_q)
         StIdle: begin
            rready = grant_r;
            bready = grant_b;
            if (grant_r || grant_b) state_d = StAlloc;
         end
         StAlloc: if (vc_found) state_d = StSend;
         StSend:  if (is_on_off[out_vc]) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         prefer_b_q   <= 1'b0;
         tag_overflow <= 1'b0;
         out_data     <= '0;
         out_resp     <= RespOkay;
         out_is_read  <= 1'b0;
         out_dest     <= '0;
         out_vc       <= '0;
      end else begin
         state_q <= state_d;
         if (rd_drop || wr_drop) tag_overflow <= 1'b1;
         if (rready) begin
            out_data    <= rdata;
            out_resp    <= rresp;
            out_is_read <= 1'b1;
            out_dest    <= rd_head;
            prefer_b_q  <= 1'b1;
         end else if (bready) begin
            out_data    <= '0;
            out_resp    <= bresp;
            out_is_read <= 1'b0;
            out_dest    <= wr_head;
            prefer_b_q  <= 1'b0;
         end
         if (state_q == StAlloc && vc_found) out_vc <= vc_sel;
      end
   end
endmodule
